// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types, default sizes and drain-length helper for the output-stationary array
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_e;
  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 20;
  localparam int KW_DEF = 8;
  function automatic int drain_len(input int n);
    return 2 * n - 1;
  endfunction
endpackage

// File: rtl/systolic_array_os_if.sv
// systolic_array_os_if: operand stream, result stream and status bundle of the systolic engine
interface systolic_array_os_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 20,
  parameter int KW = 8
);
  localparam int IW = $clog2(N);
  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_col;
  logic [N*DW-1:0] b_row;
  logic            out_valid;
  logic            out_ready;
  logic [N*AW-1:0] out_row;
  logic [IW-1:0]   out_idx;
  logic            busy;
  logic            done;
  modport master (
    output start, k_len, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, out_row, out_idx, busy, done
  );
  modport slave (
    input  start, k_len, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, out_row, out_idx, busy, done
  );
endinterface

// File: rtl/systolic_pe.sv
// systolic_pe: one MAC cell; passes a right and b down with their valid bits, accumulates on valid
module systolic_pe #(
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic [DW-1:0] a_i,
  input  logic          a_vld_i,
  input  logic [DW-1:0] b_i,
  input  logic          b_vld_i,
  output logic [DW-1:0] a_o,
  output logic          a_vld_o,
  output logic [DW-1:0] b_o,
  output logic          b_vld_o,
  output logic [AW-1:0] acc_o
);
  logic [DW-1:0]   a_q, b_q;
  logic            a_vld_q, b_vld_q;
  logic [AW-1:0]   acc_q, acc_d;
  logic [2*DW-1:0] prod;
  assign prod  = a_i * b_i;
  assign acc_d = clr_i ? '0 : (a_vld_i && b_vld_i) ? acc_q + AW'(prod) : acc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      a_q     <= a_i;
      b_q     <= b_i;
      a_vld_q <= a_vld_i;
      b_vld_q <= b_vld_i;
      acc_q   <= acc_d;
    end
  end
  assign a_o     = a_q;
  assign a_vld_o = a_vld_q;
  assign b_o     = b_q;
  assign b_vld_o = b_vld_q;
  assign acc_o   = acc_q;
endmodule

// File: rtl/systolic_array_os.sv
// systolic_array_os: N x N output-stationary matrix multiplier with input skew, fixed drain and row readout
module systolic_array_os
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int KW = KW_DEF
) (
  input logic               clk,
  input logic               rst,
  systolic_array_os_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(2 * N);
  state_e        state_q;
  logic [KW-1:0] cnt_q, klen_q;
  logic [CW-1:0] drn_q;
  logic [IW-1:0] idx_q;
  logic          done_q;
  logic          start_fire, in_fire;
  logic [DW-1:0] a_h  [N][N+1];
  logic          a_vh [N][N+1];
  logic [DW-1:0] b_v  [N+1][N];
  logic          b_vv [N+1][N];
  logic [AW-1:0] acc  [N][N];
  logic [N-1:0]  unused_edge;
  assign start_fire = (state_q == IDLE) && bus.start;
  assign in_fire    = (state_q == LOAD) && bus.in_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      klen_q  <= '0;
      drn_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          cnt_q   <= '0;
          drn_q   <= '0;
          klen_q  <= bus.k_len;
          state_q <= (bus.k_len == '0) ? DRAIN : LOAD;
        end
        LOAD: if (bus.in_valid) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q + 1'b1 == klen_q) state_q <= DRAIN;
        end
        DRAIN: begin
          drn_q <= drn_q + 1'b1;
          if (drn_q == CW'(drain_len(N) - 1)) begin
            state_q <= OUT;
            idx_q   <= '0;
          end
        end
        OUT: if (bus.out_ready) begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == IW'(N - 1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end
  // Lane i of A and B shares an i-deep chain so both reach PE(i,j) on the same edge
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_h[0][0]  = bus.a_col[DW-1:0];
      assign a_vh[0][0] = in_fire;
      assign b_v[0][0]  = bus.b_row[DW-1:0];
      assign b_vv[0][0] = in_fire;
    end else begin : g_chain
      logic [2*DW:0] ch_q [i];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < i; s++) ch_q[s] <= '0;
        end else begin
          ch_q[0] <= {in_fire, bus.a_col[i*DW +: DW], bus.b_row[i*DW +: DW]};
          for (int s = 1; s < i; s++) ch_q[s] <= ch_q[s-1];
        end
      end
      assign {a_vh[i][0], a_h[i][0], b_v[0][i]} = ch_q[i-1];
      assign b_vv[0][i] = ch_q[i-1][2*DW];
    end
    assign unused_edge[i] = ^{a_h[i][N], a_vh[i][N], b_v[N][i], b_vv[N][i]};
  end
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (start_fire),
        .a_i     (a_h[i][j]),
        .a_vld_i (a_vh[i][j]),
        .b_i     (b_v[i][j]),
        .b_vld_i (b_vv[i][j]),
        .a_o     (a_h[i][j+1]),
        .a_vld_o (a_vh[i][j+1]),
        .b_o     (b_v[i+1][j]),
        .b_vld_o (b_vv[i+1][j]),
        .acc_o   (acc[i][j])
      );
    end
  end
  always_comb begin
    bus.out_row = '0;
    for (int j = 0; j < N; j++) bus.out_row[j*AW +: AW] = (state_q == OUT) ? acc[idx_q][j] : '0;
  end
  assign bus.in_ready  = state_q == LOAD;
  assign bus.out_valid = state_q == OUT;
  assign bus.out_idx   = idx_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_systolic_array_os.sv
// tb_systolic_array_os: directed matrix runs with hand-computed results, stalls, wrap and reset cases
module tb_systolic_array_os;
  localparam int N = 4, DW = 8, AW = 20, KW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   A [N][32];
  int   B [32][N];
  int   E [N][N];
  systolic_array_os_if #(.N(N), .DW(DW), .AW(AW), .KW(KW)) bus ();
  systolic_array_os #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic feed(input int k, input int gap_at, input int gap_n);
    for (int kk = 0; kk < k; kk++) begin
      int w = 0;
      while (!bus.in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w == 50) check("in_ready_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        bus.a_col[i*DW +: DW] = 8'(A[i][kk]);
        bus.b_row[i*DW +: DW] = 8'(B[kk][i]);
      end
      @(negedge clk);
      if (kk == gap_at) begin
        bus.in_valid = 1'b0;
        bus.a_col    = '1;
        bus.b_row    = '1;
        repeat (gap_n) @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic run(input int k, input int gap_at, input int gap_n, input int hold_row,
                     input int hold_n, input int poke_row, input int lat_out, input int lat_done);
    int t0, w;
    logic [N*AW-1:0] snap;
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    feed(k, gap_at, gap_n);
    w = 0;
    while (!bus.out_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("out_valid_seen", bus.out_valid, 1);
    if (lat_out >= 0) check("first_out_latency", cyc - t0, lat_out);
    for (int r = 0; r < N; r++) begin
      check("out_idx", bus.out_idx, r);
      for (int j = 0; j < N; j++) check($sformatf("c[%0d][%0d]", r, j), bus.out_row[j*AW +: AW], E[r][j]);
      if (r == poke_row) begin
        bus.start = 1'b1;
        bus.k_len = 8'd5;
      end
      if (r == hold_row) begin
        bus.out_ready = 1'b0;
        snap = bus.out_row;
        repeat (hold_n) begin
          @(negedge clk);
          check("hold_row_stable", bus.out_row, snap);
          check("hold_idx_stable", bus.out_idx, r);
          check("hold_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("done_pulse", bus.done, 1);
    check("busy_after_run", bus.busy, 0);
    if (lat_done >= 0) check("done_latency", cyc - t0, lat_done);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_in_ready", bus.in_ready, 0);
  endtask
  task automatic fill(input int av, input int bv);
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < 32; kk++) begin
        A[i][kk] = av;
        B[kk][i] = bv;
      end
  endtask
  task automatic small_mat();
    int a3 [N][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 11, 12}};
    int b3 [3][N] = '{'{1, 0, 2, 1}, '{0, 1, 1, 2}, '{3, 1, 0, 1}};
    int e3 [N][N] = '{'{10, 5, 4, 8}, '{22, 11, 13, 20}, '{34, 17, 22, 32}, '{46, 23, 31, 44}};
    for (int i = 0; i < N; i++) for (int kk = 0; kk < 3; kk++) A[i][kk] = a3[i][kk];
    for (int kk = 0; kk < 3; kk++) for (int j = 0; j < N; j++) B[kk][j] = b3[kk][j];
    E = e3;
  endtask
  initial begin
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.in_valid  = 1'b0;
    bus.a_col     = '0;
    bus.b_row     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_row", bus.out_row, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b0;
    @(negedge clk);
    // identity A: rows read back equal B
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < N; kk++) begin
        A[i][kk] = (i == kk) ? 1 : 0;
        B[kk][i] = kk * 4 + i + 1;
      end
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) E[r][j] = r * 4 + j + 1;
    run(4, -1, 0, -1, 0, -1, 12, 16);
    small_mat();
    run(3, -1, 0, -1, 0, -1, 11, 15);
    run(3, 1, 2, 2, 5, -1, -1, -1);
    fill(255, 255);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) E[r][j] = 1040400;
    run(16, -1, 0, -1, 0, -1, 24, 28);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) E[r][j] = 56849;
    run(17, -1, 0, -1, 0, -1, 25, 29);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) E[r][j] = 0;
    run(0, -1, 0, -1, 0, 1, 8, 12);
    // reset in the middle of LOAD, then reset together with start
    fill(7, 9);
    bus.start = 1'b1;
    bus.k_len = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    feed(2, -1, 0);
    check("midload_busy", bus.busy, 1);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_row", bus.out_row, 0);
    bus.in_valid = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    check("rst_start_busy", bus.busy, 0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("after_rst_idle", bus.busy, 0);
    fill(3, 3);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) E[r][j] = 9;
    run(1, -1, 0, -1, 0, -1, 9, 13);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_array_os.md
# systolic_array_os

Parametrised N×N output-stationary systolic matrix-multiply engine, successor to the fixed 2×2 PE grid. Computes C = A·B for A (N×K) and B (K×N). Operands stream in one k-slice per cycle through a valid/ready handshake. Input skew, zero-bubble handling, accumulation, drain sequencing and row-by-row result readout are all handled internally. It sits between the operand buffers and the result writeback of the accelerator datapath.

## Interface
- N, default 4: array dimension (rows = cols), range 2..8
- DW, default 8: unsigned operand width
- AW, default 20: accumulator/result width; wraps modulo 2^AW
- KW, default 8: width of the k_len field
- clk, in, 1: clock; all state updates on the rising edge
- rst, in, 1: synchronous active-high reset
- start, in, 1: one-cycle pulse; honoured only in IDLE
- k_len, in, KW: inner dimension K; sampled on an accepted start
- in_valid, in, 1: a_col / b_row hold a valid k-slice
- in_ready, out, 1: block accepts a slice this cycle
- a_col, in, N*DW: A[0..N-1][k]; lane i at bits [i*DW +: DW]
- b_row, in, N*DW: B[k][0..N-1]; lane j at bits [j*DW +: DW]
- out_valid, out, 1: out_row holds one result row
- out_ready, in, 1: consumer takes the row
- out_row, out, N*AW: C[r][0..N-1]; lane j at bits [j*AW +: AW]
- out_idx, out, clog2(N): row index r of the row on out_row
- busy, out, 1: high in every state except IDLE
- done, out, 1: one-cycle pulse after the last row is accepted

## Operation
- States: IDLE, LOAD, DRAIN, OUT.
- IDLE → LOAD on start, or IDLE → DRAIN if k_len==0. On start, all accumulators clear and the beat counter is set to 0.
- LOAD: in_ready=1. Each in_valid&&in_ready handshake accepts one slice and increments the counter. When the count reaches K, the next state is DRAIN.
- Skew stage: row i of A is delayed i cycles and column j of B is delayed j cycles, with register chains of length 0..N-1.
- Each lane carries a valid bit alongside its data. Cycles with in_valid=0 inject a valid=0 bubble, and bubbles never accumulate.
- PE(i,j) behaviour: registers a to the right and b downward, each with its valid bit. When the incoming valid=1, acc += a*b. The product is DW*2 bits, zero-extended to AW.
- DRAIN: in_ready=0. Lasts exactly 2N-1 cycles, then moves to OUT.
- OUT: out_valid=1 and out_row = C[out_idx]. out_idx starts at 0 and advances on out_valid&&out_ready. After the row N-1 handshake, done=1 for one cycle and the state returns to IDLE.
- out_row and out_idx stay stable while out_valid=1 and out_ready=0.
- start outside IDLE is ignored. Accumulators keep their values until the next accepted start.

## Timing
- Reset (rst=1 at an edge) applies in any state, including mid-LOAD, DRAIN or OUT:
  - state goes to IDLE; counters, skew chains, valid bits and accumulators go to 0
  - in_ready=0, out_valid=0, out_row=0, out_idx=0, busy=0, done=0
- start at edge t: in_ready=1 from cycle t+1.
- Last slice accepted at edge t_L: DRAIN covers cycles t_L+1 .. t_L+2N-1, and out_valid=1 from cycle t_L+2N.
- Latency from last accept to first out_valid is 2N cycles.
- With no stalls, the total run is 1 + K + 2N-1 + N cycles from start to done.
- A simultaneous start and rst resolves to reset.
- In_valid gaps lengthen LOAD only; DRAIN length is fixed.

## Structure
- Shared package systolic_pkg holds:
  - state enum {IDLE, LOAD, DRAIN, OUT}
  - default N, DW and AW constants
  - a function computing the DRAIN length (2N-1)
- Sub-module systolic_pe holds one PE: a/b pass registers, valid pass, MAC accumulator, synchronous clear. It is instantiated N×N by generate loops.
- The skew chains and FSM live in the top module.

## Test plan
- N=4, A=I, B[k][j]=k*4+j+1, K=4, no stalls: rows read back equal B. done asserts exactly 1+4+7+4 cycles after start.
- N=4, K=3, in_valid deasserted for 2 cycles between slices 1 and 2: results identical to the no-stall run, and the result rows are unaffected by the bubbles.
- out_ready held low for 5 cycles on row 2: out_row/out_idx stable throughout, no row skipped or duplicated.
- A and B all 255, K=16, AW=20: every C entry is 16*65025 mod 2^20 = 1040400. A second run with K=17 checks wrap: 1105425 mod 2^20 = 56849.
- k_len=0: IDLE → DRAIN (7 cycles) → 4 zero rows, then done. A start pulse issued during OUT is ignored.
- rst asserted mid-LOAD after 2 slices: next cycle has busy=0, in_ready=0, out_valid=0. A fresh K=1 run with a_col=b_row=all 3 gives every C entry = 9.
